// File: rtl/cd_drive_link_pkg.sv
// ----------------------------------------------------------------------------
// cd_link_pkg
// Shared types and constants for the drive side of the CD-block SH-1 SCI0
// link: FSM state encoding, frame length and byte index constants.
// ----------------------------------------------------------------------------
package cd_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER
    } link_state_e;

    typedef logic [7:0] byte_t;
    typedef logic [3:0] byte_idx_t;

    localparam int CD_FRAME_LEN = 13;

    // First and last byte positions of the status (drive -> SH-1) and
    // command (SH-1 -> drive) frames.
    localparam byte_idx_t STAT_IDX_FIRST = 4'd0;
    localparam byte_idx_t STAT_IDX_LAST  = 4'(CD_FRAME_LEN - 1);
    localparam byte_idx_t CMD_IDX_FIRST  = 4'd0;
    localparam byte_idx_t CMD_IDX_LAST   = 4'(CD_FRAME_LEN - 1);

endpackage

// File: rtl/cd_drive_link_if.sv
// ----------------------------------------------------------------------------
// cd_drive_link_if
// Serial wires between the SH-1 SCI0 / port pins and the drive mechanism.
//   sck0o     : SH-1 serial clock, idle high
//   txd0      : SH-1 -> drive command bit
//   rxd0      : drive -> SH-1 status bit
//   comsync_n : low for the whole frame (to PB2I)
//   comreq_n  : frame-request pulse (to IRQ6N)
// master = SH-1 side, slave = drive side.
// ----------------------------------------------------------------------------
interface cd_drive_link_if;

    logic sck0o;
    logic txd0;
    logic rxd0;
    logic comsync_n;
    logic comreq_n;

    modport master (
        output sck0o,
        output txd0,
        input  rxd0,
        input  comsync_n,
        input  comreq_n
    );

    modport slave (
        input  sck0o,
        input  txd0,
        output rxd0,
        output comsync_n,
        output comreq_n
    );

endinterface

// File: rtl/cd_sci_shift.sv
// ----------------------------------------------------------------------------
// cd_sci_shift
// Bit-level engine of the link: SCK edge detection, bit counter, receive
// shift register and transmit bit selection, byte-complete strobe.
//   clk, rst  : system clock, synchronous active-high reset
//   ce_r      : clock enable
//   sck, txd  : SH-1 serial clock and command data
//   en        : frame is in the transfer phase
//   restart   : new frame, bit counter back to 0
//   tx_byte   : status byte currently being sent
//   sck_edge  : any SCK edge seen this enabled tick (watchdog clear)
//   tx_load   : drive tx_bit onto RXD0 this tick
//   tx_bit    : status bit for the current bit position
//   byte_done : 8th rising edge of a byte seen this tick
//   rx_byte   : completed command byte, valid with byte_done
// ----------------------------------------------------------------------------
module cd_sci_shift
    import cd_link_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  ce_r,
    input  logic  sck,
    input  logic  txd,
    input  logic  en,
    input  logic  restart,
    input  byte_t tx_byte,
    output logic  sck_edge,
    output logic  tx_load,
    output logic  tx_bit,
    output logic  byte_done,
    output byte_t rx_byte
);

    logic       sck_q;
    logic [2:0] bit_idx;
    logic [6:0] shreg;
    logic       fall;
    logic       rise;

    assign fall = sck_q & ~sck;
    assign rise = ~sck_q & sck;

    // Bit 0 of every byte is preset on RXD0 before the byte starts, so the
    // fall that precedes its first rise must not overwrite it.
    assign tx_load   = ce_r & en & fall & (bit_idx != 3'd0);
    assign byte_done = ce_r & en & rise & (bit_idx == 3'd7);
    assign sck_edge  = ce_r & en & (fall | rise);
    assign tx_bit    = tx_byte[bit_idx];
    // The 8th bit is taken straight from the pin on the completing edge.
    assign rx_byte   = {txd, shreg};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q   <= 1'b1;
            bit_idx <= 3'd0;
            shreg   <= '0;
        end else if (ce_r) begin
            sck_q <= sck;
            if (restart) begin
                bit_idx <= 3'd0;
            end else if (en && rise) begin
                if (bit_idx != 3'd7) begin
                    shreg[bit_idx] <= txd;
                end
                bit_idx <= bit_idx + 3'd1;  // wraps to 0 after the 8th bit
            end
        end
    end

endmodule

// File: rtl/cd_drive_link.sv
// ----------------------------------------------------------------------------
// cd_drive_link
// Drive-side end of the SH-1 SCI0 link. Shifts a status frame out on RXD0 and
// captures the command frame from TXD0, LSB first, on SH-1 generated SCK.
//   clk, rst   : system clock, synchronous active-high reset
//   ce_r       : clock enable; all state advances only when high
//   link       : serial wires (slave side of cd_drive_link_if)
//   stat_we    : write status staging byte stat_addr <= stat_data
//   start      : request a frame; ignored unless idle
//   busy       : frame in progress
//   cmd_valid  : one-clk pulse, cmd_idx/cmd_data hold a received byte
//   frame_done : one-clk pulse, whole frame exchanged
//   frame_err  : one-clk pulse, frame aborted by SCK watchdog
// ----------------------------------------------------------------------------
module cd_drive_link
    import cd_link_pkg::*;
#(
    parameter int FRAME_LEN = CD_FRAME_LEN,
    parameter int REQ_TICKS = 8,
    parameter int TIMEOUT   = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_r,
    cd_drive_link_if.slave        link,
    input  logic                  stat_we,
    input  byte_idx_t             stat_addr,
    input  byte_t                 stat_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  cmd_valid,
    output byte_idx_t             cmd_idx,
    output byte_t                 cmd_data,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int REQ_W = $clog2(REQ_TICKS + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [REQ_W-1:0] REQ_LAST = REQ_W'(REQ_TICKS - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
    localparam byte_idx_t        LAST_IDX = 4'(FRAME_LEN - 1);

    link_state_e      state_q, state_d;
    byte_t            staging [16];
    byte_t            xmit    [16];
    byte_idx_t        byte_idx;
    byte_idx_t        next_idx;
    logic [REQ_W-1:0] req_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic             rxd_q, comsync_q, comreq_q;

    logic do_start, req_end, last_byte, timeout;
    logic sck_edge, tx_load, tx_bit, byte_done;
    byte_t rx_byte;

    assign next_idx       = byte_idx + 4'd1;
    assign busy           = (state_q != IDLE);
    assign link.rxd0      = rxd_q;
    assign link.comsync_n = comsync_q;
    assign link.comreq_n  = comreq_q;

    cd_sci_shift u_shift (
        .clk       (clk),
        .rst       (rst),
        .ce_r      (ce_r),
        .sck       (link.sck0o),
        .txd       (link.txd0),
        .en        (state_q == XFER),
        .restart   (do_start),
        .tx_byte   (xmit[byte_idx]),
        .sck_edge  (sck_edge),
        .tx_load   (tx_load),
        .tx_bit    (tx_bit),
        .byte_done (byte_done),
        .rx_byte   (rx_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        do_start  = 1'b0;
        req_end   = 1'b0;
        last_byte = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ce_r && start) begin
                    do_start = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (ce_r && req_cnt == REQ_LAST) begin
                    req_end = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (byte_done && byte_idx == LAST_IDX) begin
                    last_byte = 1'b1;
                    state_d   = IDLE;
                end else if (ce_r && !sck_edge && wd_cnt == WD_LAST) begin
                    // This tick is the TIMEOUT-th without any SCK edge.
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_q      <= 1'b1;
            comsync_q  <= 1'b1;
            comreq_q   <= 1'b1;
            cmd_valid  <= 1'b0;
            cmd_idx    <= '0;
            cmd_data   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            byte_idx   <= '0;
            req_cnt    <= '0;
            wd_cnt     <= '0;
            // NOTE: the buffers are small flop arrays, so they are cleared
            // here; a RAM-based buffer would not be reset.
            for (int i = 0; i < 16; i++) begin
                staging[i] <= '0;
                xmit[i]    <= '0;
            end
        end else begin
            // Pulses last exactly one clk, independent of ce_r.
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (ce_r && stat_we) begin
                staging[stat_addr] <= stat_data;
            end

            if (do_start) begin
                // Snapshot the staging buffer so later writes cannot tear
                // the frame in flight.
                for (int i = 0; i < 16; i++) begin
                    xmit[i] <= staging[i];
                end
                rxd_q     <= staging[STAT_IDX_FIRST][0];
                byte_idx  <= CMD_IDX_FIRST;
                req_cnt   <= '0;
                wd_cnt    <= '0;
                comsync_q <= 1'b0;
                comreq_q  <= 1'b0;
            end

            if (ce_r && state_q == REQ) begin
                req_cnt <= req_cnt + 1'b1;
                if (req_end) comreq_q <= 1'b1;
            end

            if (ce_r && state_q == XFER) begin
                if (sck_edge)            wd_cnt <= '0;
                else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
            end

            if (tx_load) begin
                rxd_q <= tx_bit;
            end

            if (byte_done) begin
                cmd_valid <= 1'b1;
                cmd_idx   <= byte_idx;
                cmd_data  <= rx_byte;
                byte_idx  <= next_idx;
                if (!last_byte) rxd_q <= xmit[next_idx][0];
            end

            if (last_byte || timeout) begin
                frame_done <= last_byte;
                frame_err  <= timeout;
                comsync_q  <= 1'b1;
                rxd_q      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cd_drive_link.sv
// ----------------------------------------------------------------------------
// tb_cd_drive_link
// Directed bench for cd_drive_link: an SH-1 style SCK/TXD driver exchanges
// frames with the drive; received status bytes, command bytes and frame
// pulses are compared against hand-computed values.
// ----------------------------------------------------------------------------
module tb_cd_drive_link;
    import cd_link_pkg::*;

    localparam int HALF    = 4;     // clk per SCK half period
    localparam int TIMEOUT = 4096;

    logic      clk = 1'b0;
    logic      rst;
    logic      ce_r;
    logic      stat_we;
    byte_idx_t stat_addr;
    byte_t     stat_data;
    logic      start;
    logic      busy;
    logic      cmd_valid;
    byte_idx_t cmd_idx;
    byte_t     cmd_data;
    logic      frame_done;
    logic      frame_err;

    cd_drive_link_if link ();

    cd_drive_link dut (
        .clk        (clk),
        .rst        (rst),
        .ce_r       (ce_r),
        .link       (link),
        .stat_we    (stat_we),
        .stat_addr  (stat_addr),
        .stat_data  (stat_data),
        .start      (start),
        .busy       (busy),
        .cmd_valid  (cmd_valid),
        .cmd_idx    (cmd_idx),
        .cmd_data   (cmd_data),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Event monitor, sampled on the falling edge.
    logic [11:0] cmd_log [$];
    int          done_cnt = 0;
    int          err_cnt  = 0;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1)  cmd_log.push_back({cmd_idx, cmd_data});
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1)  err_cnt++;
    end

    byte_t rx_got [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_stat(input byte_idx_t a, input byte_t d);
        stat_we   = 1'b1;
        stat_addr = a;
        stat_data = d;
        tick();
        stat_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_req_release();
        int n;
        n = 0;
        while (link.comreq_n !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("req_release", link.comreq_n, 1'b1);
    endtask

    // SH-1 side: drive TXD on the fall, sample RXD at the rise.
    task automatic xfer_bit(input logic t, output logic r);
        link.sck0o = 1'b0;
        link.txd0  = t;
        tick(HALF);
        r = link.rxd0;
        link.sck0o = 1'b1;
        tick(HALF);
    endtask

    task automatic xfer_byte(input byte_t tx, output byte_t rx);
        logic r;
        for (int i = 0; i < 8; i++) begin
            xfer_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic xfer_bytes(input int n);
        for (int b = 0; b < n; b++) begin
            xfer_byte(8'hA0 + 8'(b), rx_got[b]);
        end
    endtask

    task automatic check_reset_outputs(input string sfx);
        check({"rxd0_rst", sfx},      link.rxd0,      1'b1);
        check({"comsync_rst", sfx},   link.comsync_n, 1'b1);
        check({"comreq_rst", sfx},    link.comreq_n,  1'b1);
        check({"busy_rst", sfx},      busy,           1'b0);
        check({"cmd_valid_rst", sfx}, cmd_valid,      1'b0);
        check({"cmd_idx_rst", sfx},   cmd_idx,        4'd0);
        check({"cmd_data_rst", sfx},  cmd_data,       8'd0);
        check({"done_rst", sfx},      frame_done,     1'b0);
        check({"err_rst", sfx},       frame_err,      1'b0);
    endtask

    initial begin
        int n;
        int c0, d0, e0;
        logic r;
        byte_t tb5;

        rst        = 1'b1;
        ce_r       = 1'b1;
        stat_we    = 1'b0;
        stat_addr  = '0;
        stat_data  = '0;
        start      = 1'b0;
        link.sck0o = 1'b1;
        link.txd0  = 1'b1;
        tick(3);

        // Reset state
        check_reset_outputs("");
        rst = 1'b0;
        tick();

        for (int i = 0; i <= int'(STAT_IDX_LAST); i++) begin
            write_stat(4'(i), 8'(i));
        end

        // Frame start: request pulse length and framing
        c0 = cmd_log.size();
        d0 = done_cnt;
        pulse_start();
        check("comsync_low_first_tick", link.comsync_n, 1'b0);
        check("busy_in_frame", busy, 1'b1);
        check("comreq_low_first_tick", link.comreq_n, 1'b0);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (link.comreq_n === 1'b0) n++;
            else break;
        end
        check("comreq_low_ticks", n, 8);
        check("rxd0_preset_bit0", link.rxd0, 1'b0);

        // Full frame exchange
        xfer_bytes(CD_FRAME_LEN);
        for (int b = 0; b < CD_FRAME_LEN; b++) begin
            check($sformatf("status_byte%0d", b), rx_got[b], 8'(b));
        end
        check("cmd_count_full", cmd_log.size() - c0, CD_FRAME_LEN);
        for (int b = 0; b < CD_FRAME_LEN; b++) begin
            if (c0 + b < cmd_log.size())
                check($sformatf("cmd_byte%0d", b), cmd_log[c0 + b], {4'(b), 8'hA0 + 8'(b)});
        end
        check("cmd_last_idx", cmd_log[cmd_log.size() - 1][11:8], CMD_IDX_LAST);
        check("done_once_full", done_cnt - d0, 1);
        check("comsync_release_full", link.comsync_n, 1'b1);
        check("busy_after_full", busy, 1'b0);
        check("rxd0_idle_full", link.rxd0, 1'b1);

        // SCK stops after 3 bytes: watchdog abort
        c0 = cmd_log.size();
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start();
        wait_req_release();
        xfer_bytes(3);
        n = HALF;   // posedges already elapsed since the last SCK rise
        for (int k = 0; k < 6000; k++) begin
            tick();
            n++;
            if (frame_err === 1'b1) break;
        end
        check("timeout_seen", frame_err, 1'b1);
        check("timeout_window", (n >= TIMEOUT && n <= TIMEOUT + 2), 1'b1);
        tick();
        check("err_once", err_cnt - e0, 1);
        check("cmd_count_timeout", cmd_log.size() - c0, 3);
        check("no_done_timeout", done_cnt - d0, 0);
        check("busy_after_timeout", busy, 1'b0);
        check("comsync_after_timeout", link.comsync_n, 1'b1);
        check("rxd0_after_timeout", link.rxd0, 1'b1);

        // Staging write during a frame does not touch the snapshot
        d0 = done_cnt;
        pulse_start();
        wait_req_release();
        write_stat(STAT_IDX_FIRST, 8'hFF);
        xfer_bytes(CD_FRAME_LEN);
        check("snapshot_old_byte0", rx_got[0], 8'h00);
        check("snapshot_byte12", rx_got[12], 8'h0C);
        check("done_snapshot", done_cnt - d0, 1);

        // START while busy is dropped; new byte0 goes out now
        c0 = cmd_log.size();
        d0 = done_cnt;
        pulse_start();
        tick(2);
        pulse_start();
        wait_req_release();
        xfer_bytes(2);
        pulse_start();
        for (int b = 2; b < CD_FRAME_LEN; b++) begin
            xfer_byte(8'hA0 + 8'(b), rx_got[b]);
        end
        check("new_byte0", rx_got[0], 8'hFF);
        check("new_byte1", rx_got[1], 8'h01);
        tick(30);
        check("busy_start_dropped", busy, 1'b0);
        check("comsync_start_dropped", link.comsync_n, 1'b1);
        check("done_single_frame", done_cnt - d0, 1);
        check("cmd_count_single_frame", cmd_log.size() - c0, CD_FRAME_LEN);

        // Reset in the middle of byte 5
        e0 = err_cnt;
        pulse_start();
        wait_req_release();
        xfer_bytes(5);
        tb5 = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            xfer_bit(tb5[i], r);
        end
        check("cmd_idx_before_rst", cmd_idx, 4'd4);
        check("busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        tick();
        check_reset_outputs("_mid");
        rst = 1'b0;
        tick(TIMEOUT / 4);
        check("no_err_after_rst", err_cnt - e0, 0);

        // Fresh frame after reset: staging was cleared
        c0 = cmd_log.size();
        d0 = done_cnt;
        pulse_start();
        check("busy_after_rst_start", busy, 1'b1);
        wait_req_release();
        xfer_bytes(CD_FRAME_LEN);
        for (int b = 0; b < CD_FRAME_LEN; b++) begin
            check($sformatf("cleared_byte%0d", b), rx_got[b], 8'h00);
        end
        check("done_after_rst", done_cnt - d0, 1);
        check("cmd_count_after_rst", cmd_log.size() - c0, CD_FRAME_LEN);
        if (c0 < cmd_log.size())
            check("cmd_first_after_rst", cmd_log[c0], {4'd0, 8'hA0});
        check("err_total", err_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
